// File: rtl/shifter_pkg.sv
// shifter_pkg: op encoding and level-to-stage distribution helpers for the funnel shifter
package shifter_pkg;
  typedef enum logic [2:0] {
    SLL  = 3'd0,
    SRL  = 3'd1,
    SRA  = 3'd2,
    ROL  = 3'd3,
    ROR  = 3'd4,
    FSL  = 3'd5,
    FSR  = 3'd6,
    RSVD = 3'd7
  } shift_op_t;

  // Earlier stages absorb the remainder when levels do not divide evenly
  function automatic int levels_in_stage(int k, int n, int stages);
    return (n + 1) / stages + ((k < (n + 1) % stages) ? 1 : 0);
  endfunction

  function automatic int first_level(int k, int n, int stages);
    return k * ((n + 1) / stages) + ((k < (n + 1) % stages) ? k : (n + 1) % stages);
  endfunction
endpackage

// File: rtl/funnel_shift_levels.sv
// funnel_shift_levels: combinational right-shift levels lo..hi of a 2W funnel
module funnel_shift_levels #(
  parameter int N  = 5,
  parameter int LO = 0,
  parameter int HI = 5
) (
  input  logic [2*(2**N)-1:0] f_i,
  input  logic [N:0]          r_i,
  output logic [2*(2**N)-1:0] f_o,
  output logic [N:0]          r_o
);
  always_comb begin
    f_o = f_i;
    for (int j = LO; j <= HI; j++) f_o = r_i[j] ? f_o >> (2**j) : f_o;
  end
  assign r_o = r_i;
endmodule

// File: rtl/pipelined_funnel_shifter.sv
// pipelined_funnel_shifter: SLL/SRL/SRA/ROL/ROR/FSL/FSR via one pipelined right-shifting funnel
module pipelined_funnel_shifter
  import shifter_pkg::*;
#(
  parameter int N      = 5,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  shift_op_t          in_op,
  input  logic [2**N-1:0]    in_a,
  input  logic [2**N-1:0]    in_b,
  input  logic [N-1:0]       in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2**N-1:0]    out_result,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int W = 2**N;
  logic [W-1:0]       hi, lo;
  logic               left;
  logic [2*W-1:0]     f_d;
  logic [N:0]         r_d;
  logic [STAGES-1:0]  v_q, v_s, adv;
  logic [2*W-1:0]     f_q [STAGES];
  logic [2*W-1:0]     f_s [STAGES];
  logic [2*W-1:0]     f_n [STAGES];
  logic [N:0]         r_q [STAGES];
  logic [N:0]         r_s [STAGES];
  logic [N:0]         r_n [STAGES];
  logic [TAG_W-1:0]   tag_q [STAGES];
  logic [TAG_W-1:0]   tag_s [STAGES];
  always_comb begin
    hi = '0;
    lo = '0;
    left = 1'b0;
    case (in_op)
      SLL: begin hi = in_a; left = 1'b1; end
      SRL: lo = in_a;
      SRA: begin hi = {W{in_a[W-1]}}; lo = in_a; end
      ROL: begin hi = in_a; lo = in_a; left = 1'b1; end
      ROR: begin hi = in_a; lo = in_a; end
      FSL: begin hi = in_a; lo = in_b; left = 1'b1; end
      FSR: begin hi = in_b; lo = in_a; end
      default: ;
    endcase
  end
  assign f_d = {hi, lo};
  // Left shifts become right shifts by W-s; s=0 yields R=W, which returns hi
  assign r_d = left ? (N+1)'(W) - {1'b0, in_shamt} : {1'b0, in_shamt};
  // Stage k can move iff some stage at or after k is empty, or the output drains
  always_comb begin
    for (int k = 0; k < STAGES; k++) adv[k] = out_ready || ((~v_q >> k) != '0);
  end
  assign in_ready = adv[0];
  always_comb begin
    v_s = STAGES'({v_q, in_valid});
    f_s[0] = f_d;
    r_s[0] = r_d;
    tag_s[0] = in_tag;
    for (int k = 1; k < STAGES; k++) begin
      f_s[k] = f_q[k-1];
      r_s[k] = r_q[k-1];
      tag_s[k] = tag_q[k-1];
    end
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = first_level(k, N, STAGES);
    localparam int HI = LO + levels_in_stage(k, N, STAGES) - 1;
    funnel_shift_levels #(.N(N), .LO(LO), .HI(HI)) u_lvl (
      .f_i(f_s[k]),
      .r_i(r_s[k]),
      .f_o(f_n[k]),
      .r_o(r_n[k])
    );
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        f_q[k] <= '0;
        r_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= !flush && (adv[k] ? v_s[k] : v_q[k]);
        if (adv[k]) begin
          f_q[k] <= f_n[k];
          r_q[k] <= r_n[k];
          tag_q[k] <= tag_s[k];
        end
      end
    end
  end
  assign out_valid  = v_q[STAGES-1];
  assign out_result = f_q[STAGES-1][W-1:0];
  assign out_tag    = tag_q[STAGES-1];
endmodule
